// File: rtl/clk_meter_pkg.sv
// Shared types and helpers for the clock frequency meter and camera-domain input conditioning.
package clk_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        REPORT  = 2'd2
    } meter_state_e;

    localparam int unsigned SYNC_STAGES = 2;

    typedef struct packed {
        logic signed [31:0] lo;
        logic signed [31:0] hi;
    } range_bounds_t;

    // Acceptance window around the expected count; a negative lower bound clamps to zero.
    function automatic range_bounds_t calc_bounds(input int exp_count, input int tol);
        range_bounds_t b;
        b.lo = 32'(exp_count - tol);
        if (b.lo < 0) begin
            b.lo = '0;
        end
        b.hi = 32'(exp_count + tol);
        return b;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizes an asynchronous input and flags its rising edges in the clk domain.
module sync_edge_det
    import clk_meter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Synchronizer chain plus one history flop for edge detection; runs continuously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_c = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/clk_freq_meter.sv
// Counts rising edges of meas_clk over a fixed CLKIN_100M gate window and range-checks the result.
// Optional macro CLK_FREQ_METER_CONT_EN: back-to-back windows after the first start.
module clk_freq_meter
    import clk_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = 1000,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned EXP_COUNT   = 240,
    parameter int unsigned TOL         = 2
) (
    input  logic             CLKIN_100M,
    input  logic             rst,
    input  logic             meas_clk,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             in_range
);

    localparam int unsigned GATE_W = $clog2(GATE_CYCLES + 1);
    localparam int unsigned CMP_W  = CNT_W + 2;

    localparam logic [GATE_W-1:0]       GATE_LOAD = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]        CNT_MAX   = '1;
    localparam range_bounds_t           BOUNDS    = calc_bounds(int'(EXP_COUNT), int'(TOL));
    localparam logic signed [CMP_W-1:0] LO_BOUND  = CMP_W'(BOUNDS.lo);
    localparam logic signed [CMP_W-1:0] HI_BOUND  = CMP_W'(BOUNDS.hi);

    meter_state_e state_q, state_d;
    logic [GATE_W-1:0] gate_q, gate_d;
    logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0]  count_d;
    logic              busy_d, done_d, in_range_d;
    logic              meas_rise_c;
    logic [CNT_W-1:0]  cnt_inc_c;
    logic signed [CMP_W-1:0] cnt_s_c;

    sync_edge_det u_sync_edge_det (
        .clk    (CLKIN_100M),
        .rst    (rst),
        .din    (meas_clk),
        .rise_c (meas_rise_c)
    );

    // State, counters and registered outputs.
    always_ff @(posedge CLKIN_100M or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gate_q     <= '0;
            edge_cnt_q <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            count      <= '0;
            in_range   <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_q     <= gate_d;
            edge_cnt_q <= edge_cnt_d;
            busy       <= busy_d;
            done       <= done_d;
            count      <= count_d;
            in_range   <= in_range_d;
        end
    end

    // Next-state, counter update and result capture; outputs land with the transition into REPORT.
    always_comb begin
        state_d    = state_q;
        gate_d     = gate_q;
        edge_cnt_d = edge_cnt_q;
        count_d    = count;
        in_range_d = in_range;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        cnt_inc_c  = (meas_rise_c && (edge_cnt_q != CNT_MAX)) ? edge_cnt_q + 1'b1 : edge_cnt_q;
        cnt_s_c    = $signed({2'b00, cnt_inc_c});

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = MEASURE;
                    gate_d     = GATE_LOAD;
                    edge_cnt_d = '0;
                    busy_d     = 1'b1;
                end
            end
            MEASURE: begin
                busy_d     = 1'b1;
                edge_cnt_d = cnt_inc_c;
                if (gate_q == '0) begin
                    state_d    = REPORT;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    count_d    = cnt_inc_c;
                    in_range_d = (cnt_s_c >= LO_BOUND) && (cnt_s_c <= HI_BOUND);
                end else begin
                    gate_d = gate_q - 1'b1;
                end
            end
            REPORT: begin
`ifdef CLK_FREQ_METER_CONT_EN
                state_d    = MEASURE;
                gate_d     = GATE_LOAD;
                edge_cnt_d = '0;
                busy_d     = 1'b1;
`else
                state_d    = IDLE;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_clk_freq_meter.sv
// Directed bench for clk_freq_meter: latency, counts, range flag, start handling, reset abort.
`timescale 1ns/1ps
module tb_clk_freq_meter;

    logic        clk;
    logic        rst;
    logic        meas_clk;
    logic        start;
    logic        busy, done, in_range;
    logic [15:0] count;
    logic        busy4, done4, in_range4;
    logic [3:0]  count4;

    int  checks   = 0;
    int  failures = 0;
    real half_ns  = 20.8335;
    bit  run      = 1'b0;

    clk_freq_meter dut (
        .CLKIN_100M (clk),
        .rst        (rst),
        .meas_clk   (meas_clk),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .count      (count),
        .in_range   (in_range)
    );

    clk_freq_meter #(.CNT_W(4)) dut4 (
        .CLKIN_100M (clk),
        .rst        (rst),
        .meas_clk   (meas_clk),
        .start      (start),
        .busy       (busy4),
        .done       (done4),
        .count      (count4),
        .in_range   (in_range4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always begin
        #(half_ns);
        if (run) meas_clk = ~meas_clk;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Pulse start, then count edges until done (0 on timeout); optional extra start pulse at edge again_at.
    task automatic measure(input int again_at, output int lat, output int nbusy);
        lat   = 0;
        nbusy = 0;
        @(negedge clk);
        start = 1'b1;
        for (int i = 1; i <= 3000; i++) begin
            @(posedge clk);
            #1;
            start = (i == again_at);
            if (busy) nbusy++;
            if (done) begin
                lat = i;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic count_dones(input int cycles, output int nd);
        nd = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
    endtask

    task automatic set_freq(input real half);
        half_ns = half;
        run     = 1'b1;
    endtask

    task automatic set_stuck(input logic lvl);
        run      = 1'b0;
        meas_clk = lvl;
    endtask

    initial begin
        int lat, nbusy, nd;
        int t[3];

        rst      = 1'b1;
        start    = 1'b0;
        meas_clk = 1'b0;
        run      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_in_range", int'(in_range), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);

`ifdef CLK_FREQ_METER_CONT_EN
        // Continuous mode: one start pulse, windows repeat every GATE_CYCLES+1 cycles.
        set_freq(20.8335);
        nd = 0;
        @(negedge clk);
        start = 1'b1;
        for (int i = 1; i <= 3100 && nd < 3; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                t[nd] = i;
                nd++;
                chk_rng("cont_count", int'(count), 239, 241);
            end
        end
        chk("cont_done1", t[0], 1001);
        chk("cont_done2", t[1], 2002);
        chk("cont_done3", t[2], 3003);
        chk("cont_ndone", nd, 3);
`else
        // 24 MHz nominal measurement.
        set_freq(20.8335);
        measure(0, lat, nbusy);
        chk("24m_latency", lat, 1001);
        chk("24m_busy_cycles", nbusy, 1000);
        chk("24m_busy_in_report", int'(busy), 0);
        chk_rng("24m_count", int'(count), 239, 241);
        chk("24m_in_range", int'(in_range), 1);
        chk("cnt4_saturate", int'(count4), 15);
        chk("cnt4_in_range", int'(in_range4), 0);
        @(posedge clk);
        #1;
        chk("done_one_cycle", int'(done), 0);

        // Extra start while busy must be ignored.
        measure(300, lat, nbusy);
        chk("dbl_latency", lat, 1001);
        chk_rng("dbl_count", int'(count), 239, 241);
        count_dones(1200, nd);
        chk("dbl_no_second_done", nd, 0);

        // Reset in the middle of a window aborts it.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (499) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_count", int'(count), 0);
        chk("abort_in_range", int'(in_range), 0);
        chk("abort_done", int'(done), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        count_dones(1100, nd);
        chk("abort_no_done", nd, 0);
        measure(0, lat, nbusy);
        chk("post_abort_latency", lat, 1001);
        chk_rng("post_abort_count", int'(count), 239, 241);
        chk("post_abort_in_range", int'(in_range), 1);

        // 25 MHz is out of the 240 +/- 2 window.
        set_freq(20.0);
        repeat (10) @(posedge clk);
        measure(0, lat, nbusy);
        chk("25m_latency", lat, 1001);
        chk_rng("25m_count", int'(count), 249, 251);
        chk("25m_in_range", int'(in_range), 0);

        // Dead clock, low then high.
        set_stuck(1'b0);
        repeat (10) @(posedge clk);
        measure(0, lat, nbusy);
        chk("stuck0_latency", lat, 1001);
        chk("stuck0_count", int'(count), 0);
        chk("stuck0_in_range", int'(in_range), 0);
        set_stuck(1'b1);
        repeat (10) @(posedge clk);
        measure(0, lat, nbusy);
        chk("stuck1_latency", lat, 1001);
        chk("stuck1_count", int'(count), 0);
        chk("stuck1_in_range", int'(in_range), 0);

        // meas_clk high across reset release gives no counted edge.
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        measure(0, lat, nbusy);
        chk("rel_high_count", int'(count), 0);

        // start held high: back-to-back windows with one IDLE cycle between.
        set_freq(20.8335);
        repeat (10) @(posedge clk);
        nd   = 0;
        t[0] = 0;
        t[1] = 0;
        t[2] = 0;
        @(negedge clk);
        start = 1'b1;
        for (int i = 1; i <= 3100 && nd < 3; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                t[nd] = i;
                nd++;
                chk_rng("held_count", int'(count), 239, 241);
            end
        end
        start = 1'b0;
        chk("held_done1", t[0], 1001);
        chk("held_done2", t[1], 2003);
        chk("held_done3", t[2], 3005);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_freq_meter.md
Name: clk_freq_meter

Overview:
- Consumer-side checker for the camera clocks produced by the clock-divider block: CLK_24M, CLK_25M, or the camera pixel clock returned by the sensor.
- Samples the clock under test as asynchronous data in the CLKIN_100M domain and counts its rising edges over a fixed gate window.
- Reports the edge count and a pass/fail range flag.
- Used at bring-up and by the camera control FSM to confirm that XCLK/PCLK are alive and on-frequency before streaming.

Parameters:
- GATE_CYCLES, 1000: gate window length in CLKIN_100M cycles (10 us).
- CNT_W, 16: width of the edge counter and the count output.
- EXP_COUNT, 240: expected edge count per window (24 MHz over 10 us).
- TOL, 2: allowed absolute deviation from EXP_COUNT for in_range.

Ports:
- CLKIN_100M  input  1  system clock; sole clock domain.
- rst  input  1  asynchronous, active-high reset.
- meas_clk  input  1  clock under test; treated as asynchronous data, never used as a clock.
- start  input  1  request one measurement; sampled only in IDLE.
- busy  output  1  high while a measurement is in progress.
- done  output  1  one-cycle pulse when count and in_range update.
- count  output  CNT_W  rising edges seen in the last window; saturating.
- in_range  output  1  |count - EXP_COUNT| <= TOL, for the last window.

Behaviour:
- Reset: asynchronous, active-high. While rst=1: busy=0, done=0, count=0, in_range=0, FSM=IDLE, synchronizer and edge-history flops=0, gate counter=0, edge counter=0.
- Input path:
  - meas_clk passes through a 2-flop synchronizer, then a history flop.
  - edge = sync_q & ~hist_q.
  - The history flop runs in every state, so no spurious edge is produced on entering MEASURE.
- Supported range: meas_clk frequency < 45 MHz, with each phase >= 11 ns. Faster clocks undercount; this is documented, not flagged.
- FSM states: IDLE, MEASURE, REPORT.
  - IDLE:
    - start=1 at cycle t -> MEASURE at t+1.
    - Gate counter loads GATE_CYCLES-1.
    - Edge counter clears to 0.
  - MEASURE:
    - busy=1.
    - Each cycle with edge=1 increments the edge counter; it saturates at 2^CNT_W-1 and never wraps.
    - Gate counter decrements each cycle.
    - When gate counter==0 -> REPORT. The edge in this final cycle is counted, giving exactly GATE_CYCLES sampled cycles.
  - REPORT (one cycle):
    - count <= edge counter.
    - in_range <= (edge counter >= EXP_COUNT-TOL) && (edge counter <= EXP_COUNT+TOL), evaluated with CNT_W+2-bit signed arithmetic; EXP_COUNT-TOL < 0 is clamped to 0.
    - done=1.
    - Next state is IDLE; busy is already 0 in this cycle.
- Latency: start sampled at t -> done pulse and new count/in_range visible at t+GATE_CYCLES+1.
- count and in_range hold their values until the next REPORT or reset.
- start while busy or in REPORT is ignored and not queued. start held high gives back-to-back measurements, with one IDLE cycle between windows.
- Reset mid-measurement aborts immediately: no done pulse, and count returns to 0.
- The 2-cycle synchronizer delay shifts the window by 2 cycles relative to start. This is accepted and not compensated.

Optional Feature:
- Macro: CLK_FREQ_METER_CONT_EN.
- When defined: continuous mode.
  - After the first start, REPORT goes directly to MEASURE, reloading the gate counter and clearing the edge counter.
  - The result is continuous windows with no IDLE gap; done pulses every GATE_CYCLES+1 cycles.
  - Only rst returns the FSM to IDLE.
- When undefined: one-shot behaviour as above; no continuous-mode logic is synthesized.

Decomposition:
- Package clk_meter_pkg holds:
  - typedef enum for the FSM states (IDLE, MEASURE, REPORT);
  - localparam SYNC_STAGES=2;
  - a function computing the in-range window bounds with clamping.
- One sub-module: sync_edge_det, containing the 2-flop synchronizer, the history flop, and the rising-edge pulse, with asynchronous active-high reset. It is reused by other camera-domain inputs (VSYNC/HREF).

Test Plan:
- 24 MHz meas_clk (41.667 ns period), start pulse at t -> done at t+1001; count in 239..241; in_range=1; busy high for exactly cycles t+1..t+1000.
- 25 MHz meas_clk (40 ns period) -> count in 249..251, in_range=0.
- meas_clk stuck at 0, then stuck at 1 -> count=0, in_range=0, done still at t+1001; no spurious edge if meas_clk is high at reset release.
- Second start pulse during busy (t+300) -> exactly one done. start held high for 3000 cycles (one-shot) -> done at t+1001, t+2003, t+3005.
- rst asserted at t+500 of a 24 MHz measurement -> busy/count/in_range=0 asynchronously, no done. A following start gives count 239..241.
- CNT_W=4, 24 MHz -> count saturates at 15, in_range=0. With CLK_FREQ_METER_CONT_EN defined -> done every 1001 cycles without re-asserting start.
